// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIF FFT scheduler.
//   fft_state_t   : scheduler FSM states.
//   fft_span      : butterfly span N>>(s+1) for stage s.
//   fft_rd_addr0  : x0 address of issue k in stage s.
//   fft_rd_addr1  : x1 address, always x0 + span.
//   fft_tw_addr   : twiddle ROM index of issue k in stage s.
//   bitrev        : bit reversal of an index (for output-order checks).
package fft_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fft_state_t;

  function automatic int fft_span(input int s, input int log2n);
    return 1 << (log2n - s - 1);
  endfunction

  // Issue k splits into a group index g (high bits) and an offset j inside
  // the group; each group covers 2*span consecutive samples.
  function automatic int fft_rd_addr0(input int k, input int s, input int log2n);
    int span;
    int j;
    int g;
    span = fft_span(s, log2n);
    j    = k & (span - 1);
    g    = k >> (log2n - 1 - s);
    return (g << (log2n - s)) | j;
  endfunction

  function automatic int fft_rd_addr1(input int k, input int s, input int log2n);
    return fft_rd_addr0(k, s, log2n) + fft_span(s, log2n);
  endfunction

  function automatic int fft_tw_addr(input int k, input int s, input int log2n);
    return (k & (fft_span(s, log2n) - 1)) << s;
  endfunction

  function automatic int bitrev(input int x, input int nbits);
    int r;
    r = 0;
    for (int i = 0; i < nbits; i++) r = (r << 1) | ((x >> i) & 1);
    return r;
  endfunction

endpackage

// File: rtl/fft_wr_delay.sv
// Write-back delay line: carries the read-issue valid and address pair
// forward DEPTH cycles so the write lands when the butterfly result is valid.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears valids only)
//   vld, a0, a1   : issue strobe and x0/x1 addresses entering the line
//   q_vld         : delayed strobe (memory write enable)
//   q_a0, q_a1    : delayed addresses, forced to 0 when q_vld is low
module fft_wr_delay #(
  parameter int DEPTH  = 5,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld,
  input  logic [ADDR_W-1:0] a0,
  input  logic [ADDR_W-1:0] a1,
  output logic              q_vld,
  output logic [ADDR_W-1:0] q_a0,
  output logic [ADDR_W-1:0] q_a1
);

  logic              vld_p [DEPTH];
  logic [ADDR_W-1:0] a0_p  [DEPTH];
  logic [ADDR_W-1:0] a1_p  [DEPTH];

  // stage boundary: valid chain, reset so pending writes are discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= vld;
      for (int i = 1; i < DEPTH; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // stage boundary: address chain, data only
  always_ff @(posedge clk) begin
    a0_p[0] <= a0;
    a1_p[0] <= a1;
    for (int i = 1; i < DEPTH; i++) begin
      a0_p[i] <= a0_p[i-1];
      a1_p[i] <= a1_p[i-1];
    end
  end

  assign q_vld = vld_p[DEPTH-1];
  assign q_a0  = q_vld ? a0_p[DEPTH-1] : '0;
  assign q_a1  = q_vld ? a1_p[DEPTH-1] : '0;

endmodule

// File: rtl/fft_dif_sched.sv
// Scheduler for one in-place radix-2 DIF FFT of N = 2^LOG2N points through a
// single shared butterfly. Output order is bit-reversed.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle request, honoured only in IDLE
//   busy, done          : busy in RUN/DRAIN; done pulses for the DONE cycle
//   stage               : current stage 0..LOG2N-1
//   rd_en, rd_addr0/1   : sample memory read strobe and x0/x1 addresses
//   tw_addr             : twiddle ROM address (valid with rd_en)
//   bf_rst              : butterfly phase realignment
//   wr_en, wr_addr0/1   : sample memory write strobe and addresses
//   cycle_cnt           : busy-cycle counter, only with FFT_SCHED_CYCLE_CNT_EN
// Optional feature macro: FFT_SCHED_CYCLE_CNT_EN.
module fft_dif_sched
  import fft_pkg::*;
#(
  parameter int LOG2N      = 4,
  parameter int BF_LATENCY = 4,
  parameter int ADDR_W     = LOG2N,
  parameter int TW_W       = LOG2N - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] stage,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [TW_W-1:0]   tw_addr,
  output logic              bf_rst,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [ADDR_W-1:0] wr_addr1
`ifdef FFT_SCHED_CYCLE_CNT_EN
  ,
  output logic [15:0]       cycle_cnt
`endif
);

  localparam int N     = 1 << LOG2N;
  localparam int CNT_W = $clog2((N > BF_LATENCY) ? N : BF_LATENCY);

  fft_state_t        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] stage_nx;
  int                k;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      stage <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      stage <= stage_nx;
    end
  end

  // cnt counts RUN cycles 0..N-1, then DRAIN cycles 0..BF_LATENCY-1.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stage_nx = stage;
    case (state)
      IDLE: begin
        cnt_nx   = '0;
        stage_nx = '0;
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (cnt == CNT_W'(N - 1)) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == CNT_W'(BF_LATENCY - 1)) begin
          cnt_nx = '0;
          if (stage == ADDR_W'(LOG2N - 1)) begin
            state_nx = DONE;
          end else begin
            state_nx = RUN;
            stage_nx = stage + 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        stage_nx = '0;
      end
    endcase
  end

  // Issue on even RUN cycles; issue index k is the RUN cycle count halved.
  always_comb begin
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
    rd_en    = (state == RUN) && !cnt[0];
    bf_rst   = (state == IDLE) || (state == DONE) || ((state == RUN) && (cnt == '0));
    k        = int'(cnt >> 1);
    rd_addr0 = '0;
    rd_addr1 = '0;
    tw_addr  = '0;
    if (rd_en) begin
      rd_addr0 = ADDR_W'(fft_rd_addr0(k, int'(stage), LOG2N));
      rd_addr1 = ADDR_W'(fft_rd_addr1(k, int'(stage), LOG2N));
      tw_addr  = TW_W'(fft_tw_addr(k, int'(stage), LOG2N));
    end
  end

  // One cycle for the synchronous read plus the butterfly latency.
  fft_wr_delay #(
    .DEPTH  (1 + BF_LATENCY),
    .ADDR_W (ADDR_W)
  ) u_wr_delay (
    .clk   (clk),
    .rst   (rst),
    .vld   (rd_en),
    .a0    (rd_addr0),
    .a1    (rd_addr1),
    .q_vld (wr_en),
    .q_a0  (wr_addr0),
    .q_a1  (wr_addr1)
  );

`ifdef FFT_SCHED_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      cycle_cnt <= '0;
    end else if (busy && (cycle_cnt != 16'hFFFF)) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/fft_dif_sched.md
Name: fft_dif_sched

Overview:
- Sequences one in-place radix-2 decimation-in-frequency FFT of N = 2^LOG2N points through a single shared butterfly_dif datapath.
- Generates dual-port sample-memory read and write addresses, the twiddle-ROM address and the butterfly phase-alignment reset.
- Sits between the FFT top-level start/done interface and the memory/ROM/butterfly datapath.
- Output is in bit-reversed order; reordering is out of scope.

Parameters:
- LOG2N, 4: log2 of FFT size; legal range 2..12.
- BF_LATENCY, 4: cycles from butterfly input-present cycle (phase 0) to result-valid cycle.
- ADDR_W, LOG2N: sample memory address width.
- TW_W, LOG2N-1: twiddle ROM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; ignored unless state is IDLE.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the FFT is complete.
- stage  out  ADDR_W  current stage index, 0..LOG2N-1.
- rd_en  out  1  sample memory read strobe (1-cycle synchronous read).
- rd_addr0  out  ADDR_W  x0 read address.
- rd_addr1  out  ADDR_W  x1 read address.
- tw_addr  out  TW_W  twiddle ROM address (1-cycle synchronous ROM).
- bf_rst  out  1  drives butterfly rst; realigns its internal phase counter.
- wr_en  out  1  sample memory write strobe.
- wr_addr0  out  ADDR_W  out_x0 write address.
- wr_addr1  out  ADDR_W  out_x1 write address.

Behaviour:
- Reset values: state IDLE; busy=0, done=0, stage=0, rd_en=0, wr_en=0; all addresses 0; bf_rst=1.
- FSM states and transitions:
  - IDLE -> RUN on start. stage=0, k=0.
  - RUN -> DRAIN after N cycles. One butterfly issues every 2 cycles, on even RUN cycles, for N/2 issues.
  - DRAIN -> RUN with stage+1 once the write pipeline is empty.
  - DRAIN -> DONE from the last stage.
  - DONE -> IDLE after 1 cycle; done=1 only in DONE.
- Issue k, stage s:
  - span = N>>(s+1).
  - j = k & (span-1).
  - g = k >> (LOG2N-1-s).
  - rd_addr0 = (g<<(LOG2N-s)) | j.
  - rd_addr1 = rd_addr0 + span.
  - tw_addr = j<<s.
  - rd_en=1 on the issue cycle t only; addresses are don't-care when rd_en=0.
- bf_rst:
  - High in IDLE, DONE and on the first RUN cycle of each stage.
  - This gives butterfly phase 0 at t+1, when the read data arrives.
  - Low otherwise.
- Write pipeline:
  - {valid, addr0, addr1} shift register, depth 1+BF_LATENCY.
  - wr_en pulses at t+1+BF_LATENCY with the same addresses as issue t.
  - Exactly N/2 writes per stage.
- Stage period is exactly N+BF_LATENCY cycles: N RUN cycles plus BF_LATENCY DRAIN cycles. The last write of a stage precedes the first read of the next stage, so there is no RAW hazard.
- Total run: start accepted at cycle c; done at c+1+LOG2N*(N+BF_LATENCY).
- start while busy: ignored, no queuing.
- start in the DONE cycle: ignored.
- rst mid-run: immediate return to IDLE; pending writes discarded, wr_en=0 next cycle.
- stage holds its final value in DONE and returns to 0 in IDLE.

Optional Feature:
- Macro: FFT_SCHED_CYCLE_CNT_EN.
- When defined:
  - Adds output cycle_cnt [15:0].
  - Clears on start acceptance and increments every busy cycle, saturating at 16'hFFFF.
  - Holds after done; resets to 0.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package fft_pkg holds:
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - Function for the address math (addr0/addr1/tw given k, s, LOG2N).
  - Function bitrev() for benches.
- One sub-module, fft_wr_delay: parameterized valid+address shift register of depth 1+BF_LATENCY.

Test Plan:
- Reset then a single start with LOG2N=4, BF_LATENCY=4:
  - Stage 0 reads (0,8),(1,9)..(7,15) with tw 0..7.
  - done at exactly 81 cycles after the start cycle.
- Stage address check (LOG2N=4):
  - Stage 1 pairs (0,4),(1,5),(2,6),(3,7),(8,12).. with tw 0,2,4,6,0,2,4,6.
  - Stage 3 pairs (0,1),(2,3)..(14,15) with tw all 0.
- Write timing:
  - Every wr_en occurs exactly 5 cycles after its matching rd_en, with identical address pairs.
  - 8 writes per stage.
  - No read in stage s+1 before the last write of stage s.
- start pulsed at cycles 10 and 40 of a busy run:
  - Ignored.
  - busy stays continuous; a single done occurs.
- rst asserted mid-stage 2:
  - Next cycle: busy=0, rd_en=0, wr_en=0, bf_rst=1.
  - A following start completes normally in 81 cycles.
- With FFT_SCHED_CYCLE_CNT_EN and LOG2N=4: cycle_cnt=80 after done and holds.
- End-to-end with the butterfly and a memory model: impulse at x[0]=1.0 gives all 16 outputs equal to 1.0.
